// File: rtl/tbuf_bus_ctrl.sv
// tbuf_bus_ctrl: clocked round-robin controller for a shared tristate bus.
// NCH requesters take turns driving one WIDTH-bit bus through tristate
// buffers, optionally inverted to match the legacy inverting buffer cell.
// Ownership only changes after the bus has been released to all-Z, so two
// channels never drive at the same time.
// Optional feature: define TBUF_BUS_PREEMPT_EN to force an owner off the bus
// after MAX_HOLD drive cycles while another channel is waiting.
module tbuf_bus_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int TURN     = 1,
  parameter int INVERT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*WIDTH-1:0]     data,
  output logic [NCH-1:0]           gnt,
  output logic [$clog2(NCH)-1:0]   owner,
  output logic                     bus_oe,
  inout  wire  [WIDTH-1:0]         bus
);

  localparam int OW = $clog2(NCH);
  localparam int TW = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURNAROUND
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [NCH-1:0]    gnt_d;
  logic [OW-1:0]     owner_d;
  logic              oe_d;
  logic [OW-1:0]     ptr_q;
  logic [OW-1:0]     ptr_d;
  logic [TW-1:0]     turn_q;
  logic [TW-1:0]     turn_d;

  logic [NCH-1:0]    owner_oh;
  logic [NCH-1:0]    arb_mask;
  logic              arb_valid;
  logic [OW-1:0]     arb_idx;
  logic [OW-1:0]     cand;
  logic              force_rel;

  logic [WIDTH-1:0]  ch_data [NCH];
  logic [WIDTH-1:0]  own_data;
  logic [WIDTH-1:0]  drive_val;

  assign owner_oh = {{(NCH-1){1'b0}}, 1'b1} << owner;

  // After a zero-turnaround release the old owner sits out the immediate
  // re-arbitration; everywhere else every raised request competes.
  assign arb_mask = (state_q == TURNAROUND) ? (req & ~owner_oh) : req;

  // Round-robin search: the first raised request after the pointer wins,
  // wrapping, so the most recent winner has the lowest priority. Walking the
  // offsets from farthest to nearest lets the nearest candidate overwrite.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = OW'((int'(ptr_q) + k) % NCH);
      if (arb_mask[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
  end

`ifdef TBUF_BUS_PREEMPT_EN
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q;
  logic          others_req;

  assign others_req = |(req & ~owner_oh);

  // A zero limit disables preemption; otherwise the owner is released on the
  // edge that would complete its MAX_HOLD-th contested drive cycle.
  assign force_rel = (MAX_HOLD > 0) && (state_q == DRIVE) && others_req &&
                     (hold_q == HW'(MAX_HOLD - 1));

  // Count contested drive cycles of the current owner; any change of
  // ownership (including leaving DRIVE) starts the count over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (state_q == DRIVE && state_d == DRIVE) begin
      if (others_req) begin
        hold_q <= hold_q + HW'(1);
      end
    end else begin
      hold_q <= '0;
    end
  end
`else
  // Without preemption an owner keeps the bus for as long as it requests it;
  // the hold limit has no effect in this build.
  assign force_rel = 1'b0 && (MAX_HOLD != 0);
`endif

  // Next-state and next-output logic; grants, owner and enable are all
  // registered so the bus enable never glitches on request changes.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    owner_d = owner;
    oe_d    = bus_oe;
    ptr_d   = ptr_q;
    turn_d  = turn_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << arb_idx;
          owner_d = arb_idx;
          oe_d    = 1'b1;
          ptr_d   = arb_idx;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!req[owner] || force_rel) begin
          gnt_d   = '0;
          oe_d    = 1'b0;
          state_d = TURNAROUND;
          if (TURN > 0) begin
            turn_d = TW'(TURN - 1);
          end else begin
            turn_d = '0;
          end
        end
      end
      TURNAROUND: begin
        if (TURN == 0) begin
          if (arb_valid) begin
            gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << arb_idx;
            owner_d = arb_idx;
            oe_d    = 1'b1;
            ptr_d   = arb_idx;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end else if (turn_q == '0) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately and
  // parks the pointer on the last channel so channel 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      bus_oe  <= 1'b0;
      ptr_q   <= OW'(NCH - 1);
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      bus_oe  <= oe_d;
      ptr_q   <= ptr_d;
      turn_q  <= turn_d;
    end
  end

  // Split the flat data vector into per-channel words for owner selection.
  for (genvar g = 0; g < NCH; g++) begin : g_split
    assign ch_data[g] = data[g*WIDTH +: WIDTH];
  end

  assign own_data  = ch_data[owner];
  assign drive_val = (INVERT != 0) ? ~own_data : own_data;
  assign bus       = bus_oe ? drive_val : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tbuf_bus_ctrl.sv
// tb_tbuf_bus_ctrl: directed self-checking bench for tbuf_bus_ctrl.
// Three instances share clock and reset: A (TURN=1, inverting), B (TURN=0,
// true data) and C (NCH=3, TURN=2, 4-bit bus).
module tb_tbuf_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [2:0]  req_c;
  logic [31:0] data_a, data_b;
  logic [11:0] data_c;
  logic [3:0]  gnt_a, gnt_b;
  logic [2:0]  gnt_c;
  logic [1:0]  owner_a, owner_b, owner_c;
  logic        oe_a, oe_b, oe_c;
  wire  [7:0]  bus_a, bus_b;
  wire  [3:0]  bus_c;

  int n_cmp = 0;
  int n_err = 0;

  tbuf_bus_ctrl #(.WIDTH(8), .NCH(4), .TURN(1), .INVERT(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .data(data_a),
    .gnt(gnt_a), .owner(owner_a), .bus_oe(oe_a), .bus(bus_a));

  tbuf_bus_ctrl #(.WIDTH(8), .NCH(4), .TURN(0), .INVERT(0), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .data(data_b),
    .gnt(gnt_b), .owner(owner_b), .bus_oe(oe_b), .bus(bus_b));

  tbuf_bus_ctrl #(.WIDTH(4), .NCH(3), .TURN(2), .INVERT(0), .MAX_HOLD(4)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .data(data_c),
    .gnt(gnt_c), .owner(owner_c), .bus_oe(oe_c), .bus(bus_c));

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case some wait never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (gnt_a !== 4'b0000) begin
        n_err++;
        $display("[TB] FAIL reset_gnt_a cycle %0d: got %b expected 0000", i, gnt_a);
      end
      n_cmp++;
      if (oe_a !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL reset_oe_a cycle %0d: got %b expected 0", i, oe_a);
      end
      n_cmp++;
      if (owner_a !== 2'd0) begin
        n_err++;
        $display("[TB] FAIL reset_owner_a cycle %0d: got %0d expected 0", i, owner_a);
      end
      n_cmp++;
      if ({gnt_b, gnt_c, oe_b, oe_c} !== 9'b0) begin
        n_err++;
        $display("[TB] FAIL reset_bc cycle %0d: got %b expected all zero", i, {gnt_b, gnt_c, oe_b, oe_c});
      end
    end
  endtask

  task automatic test_grant_invert();
    req_a = 4'b0001;
    n_cmp++;
    if (gnt_a !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL grant_latency: got %b expected 0000 before edge", gnt_a);
    end
    step();
    n_cmp++;
    if (gnt_a !== 4'b0001 || owner_a !== 2'd0 || oe_a !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL grant_ch0: got gnt=%b owner=%0d oe=%b expected 0001/0/1", gnt_a, owner_a, oe_a);
    end
    n_cmp++;
    if (bus_a !== 8'hA5) begin
      n_err++;
      $display("[TB] FAIL bus_invert: got %h expected a5", bus_a);
    end
    data_a[7:0] = 8'h00;
    #1;
    n_cmp++;
    if (bus_a !== 8'hFF) begin
      n_err++;
      $display("[TB] FAIL bus_passthrough: got %h expected ff", bus_a);
    end
    data_a[7:0] = 8'h5A;
  endtask

  task automatic test_turnaround();
    req_a = 4'b0100;
    step();
    n_cmp++;
    if (gnt_a !== 4'b0000 || oe_a !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ta_release: got gnt=%b oe=%b expected 0000/0", gnt_a, oe_a);
    end
    step();
    n_cmp++;
    if (gnt_a !== 4'b0000 || oe_a !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ta_idle: got gnt=%b oe=%b expected 0000/0", gnt_a, oe_a);
    end
    step();
    n_cmp++;
    if (gnt_a !== 4'b0100 || owner_a !== 2'd2 || bus_a !== 8'h69) begin
      n_err++;
      $display("[TB] FAIL ta_grant2: got gnt=%b owner=%0d bus=%h expected 0100/2/69", gnt_a, owner_a, bus_a);
    end

    req_b = 4'b0001;
    step();
    n_cmp++;
    if (gnt_b !== 4'b0001 || bus_b !== 8'h11) begin
      n_err++;
      $display("[TB] FAIL t0_grant0: got gnt=%b bus=%h expected 0001/11", gnt_b, bus_b);
    end
    req_b = 4'b0100;
    step();
    n_cmp++;
    if (gnt_b !== 4'b0000 || oe_b !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL t0_gap: got gnt=%b oe=%b expected 0000/0", gnt_b, oe_b);
    end
    step();
    n_cmp++;
    if (gnt_b !== 4'b0100 || owner_b !== 2'd2 || bus_b !== 8'h33) begin
      n_err++;
      $display("[TB] FAIL t0_grant2: got gnt=%b owner=%0d bus=%h expected 0100/2/33", gnt_b, owner_b, bus_b);
    end

    req_c = 3'b100;
    step();
    n_cmp++;
    if (gnt_c !== 3'b100 || owner_c !== 2'd2 || bus_c !== 4'h9) begin
      n_err++;
      $display("[TB] FAIL t2_grant2: got gnt=%b owner=%0d bus=%h expected 100/2/9", gnt_c, owner_c, bus_c);
    end
    req_c = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (gnt_c !== 3'b000 || oe_c !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL t2_gap cycle %0d: got gnt=%b oe=%b expected 000/0", i, gnt_c, oe_c);
      end
    end
    step();
    n_cmp++;
    if (gnt_c !== 3'b001 || owner_c !== 2'd0 || bus_c !== 4'h3) begin
      n_err++;
      $display("[TB] FAIL t2_grant0: got gnt=%b owner=%0d bus=%h expected 001/0/3", gnt_c, owner_c, bus_c);
    end
  endtask

  task automatic test_rerequest();
    req_a = 4'b0000;
    step();
    req_a = 4'b0100;
    n_cmp++;
    if (gnt_a !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL rereq_release: got %b expected 0000", gnt_a);
    end
    step();
    n_cmp++;
    if (gnt_a !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL rereq_window: got %b expected 0000", gnt_a);
    end
    step();
    n_cmp++;
    if (gnt_a !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL rereq_grant: got %b expected 0100", gnt_a);
    end
  endtask

  task automatic test_dropped_request();
    req_b = 4'b0101;
    step();
    req_b = 4'b0100;
    step();
    n_cmp++;
    if (gnt_b !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL drop_hold: got %b expected 0100", gnt_b);
    end
    req_b = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (gnt_b !== 4'b0000 || oe_b !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL drop_unserved cycle %0d: got gnt=%b oe=%b expected 0000/0", i, gnt_b, oe_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    int        exp_order [5] = '{0, 1, 2, 3, 0};
    logic [1:0] e;
    logic [7:0] exp_bus;
    do_reset();
    req_a = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int waited = 0;
      e = 2'(exp_order[n]);
      while (gnt_a === 4'b0000 && waited < 8) begin
        step();
        waited++;
        n_cmp++;
        if ($countones(gnt_a) > 1 || (oe_a === 1'b1 && $isunknown(bus_a))) begin
          n_err++;
          $display("[TB] FAIL rr_integrity: got gnt=%b bus=%h expected one-hot and known", gnt_a, bus_a);
        end
      end
      exp_bus = ~data_a[e*8 +: 8];
      n_cmp++;
      if (gnt_a !== (4'b0001 << e) || owner_a !== e || bus_a !== exp_bus) begin
        n_err++;
        $display("[TB] FAIL rr_grant %0d: got gnt=%b owner=%0d bus=%h expected owner %0d bus %h (waited %0d)",
                 n, gnt_a, owner_a, bus_a, e, exp_bus, waited);
      end
      step();
      n_cmp++;
      if (gnt_a !== (4'b0001 << e)) begin
        n_err++;
        $display("[TB] FAIL rr_hold %0d: got %b expected owner %0d", n, gnt_a, e);
      end
      req_a[e] = 1'b0;
      step();
      req_a[e] = 1'b1;
      n_cmp++;
      if (gnt_a !== 4'b0000 || oe_a !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL rr_release %0d: got gnt=%b oe=%b expected 0000/0", n, gnt_a, oe_a);
      end
    end
    req_a = 4'b0000;
  endtask

  task automatic test_preempt();
    do_reset();
    req_a = 4'b0001;
    step();
    n_cmp++;
    if (gnt_a !== 4'b0001) begin
      n_err++;
      $display("[TB] FAIL pre_grant0: got %b expected 0001", gnt_a);
    end
    req_a = 4'b0011;
`ifdef TBUF_BUS_PREEMPT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (gnt_a !== 4'b0001) begin
        n_err++;
        $display("[TB] FAIL pre_hold cycle %0d: got %b expected 0001", i, gnt_a);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (gnt_a !== 4'b0000 || oe_a !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL pre_release cycle %0d: got gnt=%b oe=%b expected 0000/0", i, gnt_a, oe_a);
      end
    end
    step();
    n_cmp++;
    if (gnt_a !== 4'b0010 || owner_a !== 2'd1) begin
      n_err++;
      $display("[TB] FAIL pre_grant1: got gnt=%b owner=%0d expected 0010/1", gnt_a, owner_a);
    end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      n_cmp++;
      if (gnt_a !== 4'b0001) begin
        n_err++;
        $display("[TB] FAIL nopre_hold cycle %0d: got %b expected 0001", i, gnt_a);
      end
    end
`endif
    req_a = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_a = 4'b0010;
    step();
    n_cmp++;
    if (gnt_a !== 4'b0010 || oe_a !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ar_grant1: got gnt=%b oe=%b expected 0010/1", gnt_a, oe_a);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt_a !== 4'b0000 || oe_a !== 1'b0 || owner_a !== 2'd0) begin
      n_err++;
      $display("[TB] FAIL ar_immediate: got gnt=%b oe=%b owner=%0d expected 0000/0/0", gnt_a, oe_a, owner_a);
    end
    #1;
    rst = 1'b0;
    req_a = 4'b0011;
    step();
    n_cmp++;
    if (gnt_a !== 4'b0001 || owner_a !== 2'd0) begin
      n_err++;
      $display("[TB] FAIL ar_ch0_first: got gnt=%b owner=%0d expected 0001/0", gnt_a, owner_a);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    rst    = 1'b1;
    req_a  = '0;
    req_b  = '0;
    req_c  = '0;
    data_a = {8'hE1, 8'h96, 8'h3C, 8'h5A};
    data_b = {8'h44, 8'h33, 8'h22, 8'h11};
    data_c = {4'h9, 4'h6, 4'h3};
    test_reset();
    test_grant_invert();
    test_turnaround();
    test_rerequest();
    test_dropped_request();
    test_back_to_back();
    test_preempt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
